// File: rtl/seq_comparator_chunked_if.sv
// seq_comparator_chunked_if: start/busy/done compare handshake, operands and one-hot result.
interface seq_comparator_chunked_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             ET;
    logic             GT;
    logic             LT;
    modport master (output start, A, B, signed_mode, input busy, done, ET, GT, LT);
    modport slave  (input start, A, B, signed_mode, output busy, done, ET, GT, LT);
endinterface

// File: rtl/seq_comparator_chunked.sv
// seq_comparator_chunked: multi-cycle magnitude compare, CHUNK bits per clock, MSB chunk first.
// Define CMP_EARLY_EXIT_EN to finish at the first differing chunk instead of always taking NCHUNK cycles.
module seq_comparator_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic clk,
    input logic rst,
    seq_comparator_chunked_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_param_err
        $error("seq_comparator_chunked: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r;
    logic             sm_r;
    logic [IW-1:0]    idx;
    logic             decided, gt_acc, lt_acc;
    logic             busy, done, et, gt, lt;

    logic [CHUNK-1:0] flip, a_c, b_c;
    logic             c_gt, c_lt, gt_n, lt_n, dec_n, last;

    // Flipping the sign bit of the top chunk turns a two's-complement compare into an unsigned one.
    always_comb begin
        flip  = (sm_r && idx == IW'(NCHUNK - 1)) ? CHUNK'(1) << (CHUNK - 1) : '0;
        a_c   = a_r[int'(idx) * CHUNK +: CHUNK] ^ flip;
        b_c   = b_r[int'(idx) * CHUNK +: CHUNK] ^ flip;
        c_gt  = a_c > b_c;
        c_lt  = a_c < b_c;
        gt_n  = decided ? gt_acc : c_gt;
        lt_n  = decided ? lt_acc : c_lt;
        dec_n = decided | c_gt | c_lt;
`ifdef CMP_EARLY_EXIT_EN
        last  = idx == '0 || dec_n;
`else
        last  = idx == '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sm_r    <= 1'b0;
            idx     <= '0;
            decided <= 1'b0;
            gt_acc  <= 1'b0;
            lt_acc  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            et      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state   <= RUN;
                    a_r     <= bus.A;
                    b_r     <= bus.B;
                    sm_r    <= bus.signed_mode;
                    idx     <= IW'(NCHUNK - 1);
                    decided <= 1'b0;
                    gt_acc  <= 1'b0;
                    lt_acc  <= 1'b0;
                    busy    <= 1'b1;
                    et      <= 1'b0;
                    gt      <= 1'b0;
                    lt      <= 1'b0;
                end
                RUN: begin
                    decided <= dec_n;
                    gt_acc  <= gt_n;
                    lt_acc  <= lt_n;
                    idx     <= idx - 1'b1;
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        et    <= ~(gt_n | lt_n);
                        gt    <= gt_n;
                        lt    <= lt_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.ET   = et;
    assign bus.GT   = gt;
    assign bus.LT   = lt;
endmodule

// File: tb/tb_seq_comparator_chunked.sv
// tb_seq_comparator_chunked: directed vectors, expected results queued and checked by a done monitor.
module tb_seq_comparator_chunked;
    localparam logic [2:0] R_EQ = 3'b100, R_GT = 3'b010, R_LT = 3'b001;

    typedef struct {
        logic [2:0] r;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    seq_comparator_chunked_if #(.WIDTH(16)) bus();
    seq_comparator_chunked #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
`ifdef CMP_EARLY_EXIT_EN
        return k;
`else
        return k > 0 ? 4 : 4;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy) check("zero_while_busy", {29'd0, bus.ET, bus.GT, bus.LT}, 32'd0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {29'd0, bus.ET, bus.GT, bus.LT}, {29'd0, e.r});
                    check("latency", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called at a negedge; start is seen at the next rising edge.
    task automatic go(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic [2:0] r, input int k);
        exp_t e;
        bus.A = a;
        bus.B = b;
        bus.signed_mode = sm;
        bus.start = 1'b1;
        e.r = r;
        e.due = cyc + 1 + lat(k);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic [2:0] r, input int k);
        wait_idle();
        go(a, b, sm, r, k);
        wait_idle();
        @(negedge clk);
        @(negedge clk);
        check("hold", {29'd0, bus.ET, bus.GT, bus.LT}, {29'd0, r});
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {27'd0, bus.busy, bus.done, bus.ET, bus.GT, bus.LT}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(16'hA5A5, 16'hA5A5, 1'b0, R_EQ, 4);
        run(16'h1200, 16'h11FF, 1'b0, R_GT, 2);
        run(16'hFFFF, 16'h0001, 1'b1, R_LT, 1);
        run(16'hFFFF, 16'h0001, 1'b0, R_GT, 1);
        run(16'h7FFF, 16'h8000, 1'b1, R_GT, 1);
        run(16'h1234, 16'h1235, 1'b0, R_LT, 4);
        run(16'h8000, 16'h8001, 1'b1, R_LT, 4);

        // start again while busy with different data: ignored
        wait_idle();
        go(16'h0010, 16'h0020, 1'b0, R_LT, 3);
        bus.A = 16'hFFFF;
        bus.B = 16'h0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_held", {31'd0, bus.busy}, 32'd1);
        wait_idle();

        // start asserted in the done cycle
        @(negedge clk);
        go(16'h4000, 16'h3FFF, 1'b0, R_GT, 1);
        begin
            int n = 0;
            while (!bus.done && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bus.done) check("done_timeout", 32'd1, 32'd0);
        end
        go(16'h0000, 16'h0000, 1'b0, R_EQ, 4);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle();

        // abort during RUN cycle 2
        @(negedge clk);
        go(16'h1111, 16'h2222, 1'b0, R_LT, 1);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_outs", {27'd0, bus.busy, bus.done, bus.ET, bus.GT, bus.LT}, 32'd0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, bus.done}, 32'd0);
        end
        run(16'h0000, 16'h8000, 1'b1, R_GT, 1);

        repeat (3) @(negedge clk);
        check("queue_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_comparator_chunked.md
Name: seq_comparator_chunked

Overview:
- Parametrised multi-cycle magnitude comparator; successor to the 4-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first, with start/busy/done handshake.
- Supports unsigned and two's-complement modes.
- Used where wide compares must not sit on one combinational path, e.g. threshold checks in datapath control.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK, a localparam, not overridable.
- Elaboration error if WIDTH % CHUNK != 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when busy=0.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- ET  output  1  A == B.
- GT  output  1  A > B.
- LT  output  1  A < B.

Behaviour:
- Single clock; synchronous active-high reset.
- Reset: state=IDLE; busy=0, done=0, ET=0, GT=0, LT=0. Captured operands and chunk index are cleared. Reset mid-compare aborts with no done pulse.
- FSM states: IDLE and RUN.
- IDLE, start=1 at edge E:
  - capture A, B and signed_mode; index = NCHUNK-1; busy=1; ET=GT=LT=0; go to RUN.
- RUN, each edge: compare chunk[index] of captured A vs B.
  - Unsigned compare, except the top chunk when signed_mode=1: invert the MSB of both top chunks before comparing.
  - Only the first differing chunk, scanning from MSB, determines the result. Later chunks are ignored via an internal "decided" flag.
  - After the edge processing index 0: go to IDLE, busy=0, done=1 for exactly one cycle.
  - Result from that edge: GT=1 or LT=1 from the first differing chunk; ET=1 if no chunk differed.
- Latency:
  - start accepted at edge E -> done high after edge E+NCHUNK. With WIDTH=16, CHUNK=4: 4 cycles.
  - Throughput: one compare per NCHUNK+1 cycles. The next start may be asserted during the done cycle and is accepted at the following edge.
- Exactly one of ET/GT/LT is high after any completed compare; all three are 0 while busy.
- Results hold after done until the next accepted start.
- start while busy=1 is ignored; there is no queuing.
- A, B and signed_mode changing while busy have no effect.
- start and rst high on the same edge: reset wins.
- CHUNK=WIDTH is legal: single RUN cycle, latency 1.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: RUN terminates at the edge that processes the first differing chunk. done pulses after that edge.
  - Latency = k cycles, where k = 1-based position of the first differing chunk from the MSB.
  - Equal operands still take NCHUNK cycles.
- Not defined: latency is always NCHUNK, independent of data.
- Result values are identical in both builds.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: rst=1 for 2 cycles -> busy=0, done=0, ET=GT=LT=0.
- Unsigned equal: A=16'hA5A5, B=16'hA5A5, signed_mode=0, start pulse -> done 4 cycles later, ET=1, GT=0, LT=0.
- Unsigned, difference below a later chunk: A=16'h1200, B=16'h11FF, signed_mode=0 -> GT=1, LT=0, ET=0.
  - Early-exit build: done after 2 cycles (chunk 2 differs).
  - Default build: done after 4 cycles.
- Signed: A=16'hFFFF (-1), B=16'h0001, signed_mode=1 -> LT=1. Same operands with signed_mode=0 -> GT=1.
- Handshake:
  - Second start while busy is ignored; busy stays 1 and only one done pulse occurs.
  - start held high in the done cycle -> new compare accepted next edge; ET/GT/LT read 0 while busy.
- Abort: rst asserted at RUN cycle 2 -> next cycle busy=0, no done pulse, outputs 0.
  - A following compare, A=16'h0000 vs B=16'h8000, signed_mode=1 -> GT=1.
